// File: rtl/aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// aes_round_sequencer
//
// Sequences one AES-128 encryption through an external, purely combinational
// AES operations unit. Each non-idle FSM state issues exactly one operation
// (AddRoundKey, key expansion, SubBytes, ShiftRows, MixColumns) and captures
// the returned value on the following rising edge. Lane contents are opaque
// here: the sequencer only routes blocks between its registers and the unit.
//
// Ports
//   clk         : single clock, all state changes on the rising edge
//   rst         : synchronous active-high reset (priority over start)
//   start       : request to encrypt one block, sampled only in IDLE
//   plaintext   : input block, captured on the start-accept edge
//   cipher_key  : AES-128 key, captured on the start-accept edge
//   busy        : high whenever the FSM is not in IDLE
//   done        : one-cycle pulse when ciphertext becomes valid
//   ciphertext  : last completed result, held until the next completion
//   aes_op1     : operand 1 to the AES operations unit
//   aes_op2     : operand 2 to the AES operations unit (0 when unused)
//   aes_sel     : operation select to the AES operations unit
//   aes_result  : combinational result from the AES operations unit
// -----------------------------------------------------------------------------
module aes_round_sequencer #(
   parameter int regSize = 32,
   parameter int vecSize = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic [vecSize-1:0][regSize-1:0] plaintext,
   input  logic [vecSize-1:0][regSize-1:0] cipher_key,
   output logic                            busy,
   output logic                            done,
   output logic [vecSize-1:0][regSize-1:0] ciphertext,
   output logic [vecSize-1:0][regSize-1:0] aes_op1,
   output logic [vecSize-1:0][regSize-1:0] aes_op2,
   output logic [2:0]                      aes_sel,
   input  logic [vecSize-1:0][regSize-1:0] aes_result
);

   typedef logic [vecSize-1:0][regSize-1:0] blk_t;

   typedef enum logic [2:0] {
      IDLE,
      INIT_ARK,
      KEXP,
      SUB,
      SHIFT,
      MIX,
      ARK
   } state_t;

   localparam logic [2:0] OP_IDLE  = 3'b000;
   localparam logic [2:0] OP_KEXP  = 3'b001;
   localparam logic [2:0] OP_SUB   = 3'b010;
   localparam logic [2:0] OP_SHIFT = 3'b011;
   localparam logic [2:0] OP_MIX   = 3'b100;
   localparam logic [2:0] OP_ARK   = 3'b101;

   localparam logic [3:0] LAST_ROUND = 4'd10;

   state_t     state;
   state_t     next_state;
   blk_t       state_reg;
   blk_t       key_reg;
   logic [3:0] round;

   assign busy = (state != IDLE);

   // Next-state and operand steering. The unit's result is consumed in the
   // same cycle, so operands depend only on the current state and registers.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a signal unassigned, which would otherwise infer a latch.
      next_state = state;
      aes_sel    = OP_IDLE;
      aes_op1    = '0;
      aes_op2    = '0;
      case (state)
         IDLE: begin
            if (start) next_state = INIT_ARK;
         end
         INIT_ARK: begin
            aes_sel    = OP_ARK;
            aes_op1    = state_reg;
            aes_op2    = key_reg;
            next_state = KEXP;
         end
         KEXP: begin
            // The round number selects the round constant inside the unit.
            aes_sel    = OP_KEXP;
            aes_op1    = key_reg;
            aes_op2[0] = regSize'(round);
            next_state = SUB;
         end
         SUB: begin
            aes_sel    = OP_SUB;
            aes_op1    = state_reg;
            next_state = SHIFT;
         end
         SHIFT: begin
            // The final round skips MixColumns.
            aes_sel    = OP_SHIFT;
            aes_op1    = state_reg;
            next_state = (round < LAST_ROUND) ? MIX : ARK;
         end
         MIX: begin
            aes_sel    = OP_MIX;
            aes_op1    = state_reg;
            next_state = ARK;
         end
         ARK: begin
            aes_sel    = OP_ARK;
            aes_op1    = state_reg;
            aes_op2    = key_reg;
            next_state = (round < LAST_ROUND) ? KEXP : IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // State register and datapath capture.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (rst) begin
         state      <= IDLE;
         round      <= '0;
         done       <= 1'b0;
         ciphertext <= '0;
         // Block and key registers are cleared too, so an aborted encryption
         // leaves no plaintext or key material behind.
         state_reg  <= '0;
         key_reg    <= '0;
      end else begin
         state <= next_state;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state_reg <= plaintext;
                  key_reg   <= cipher_key;
                  round     <= '0;
               end
            end
            INIT_ARK: begin
               state_reg <= aes_result;
               round     <= 4'd1;
            end
            KEXP: begin
               key_reg <= aes_result;
            end
            SUB, SHIFT, MIX: begin
               state_reg <= aes_result;
            end
            ARK: begin
               if (round < LAST_ROUND) begin
                  state_reg <= aes_result;
                  round     <= round + 4'd1;
               end else begin
                  ciphertext <= aes_result;
                  done       <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// tb_aes_round_sequencer
//
// Self-checking bench for aes_round_sequencer. It supplies a behavioural AES
// operations unit (byte-level FIPS-197 primitives) and a transaction-level
// model: a block accepted in IDLE completes 50 edges later with the full AES
// encryption of the captured plaintext/key. A single compare process checks
// busy, done, ciphertext, aes_sel and operand gating every cycle after reset;
// directed sequences add known-answer, latency and back-to-back checks.
// -----------------------------------------------------------------------------
module tb_aes_round_sequencer;

   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam int           LAT   = 50;

   logic             clk;
   logic             rst;
   logic             start;
   logic [3:0][31:0] plaintext;
   logic [3:0][31:0] cipher_key;
   logic             busy;
   logic             done;
   logic [3:0][31:0] ciphertext;
   logic [3:0][31:0] aes_op1;
   logic [3:0][31:0] aes_op2;
   logic [2:0]       aes_sel;
   logic [3:0][31:0] aes_result;

   aes_round_sequencer #(.regSize(32), .vecSize(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .plaintext  (plaintext),
      .cipher_key (cipher_key),
      .busy       (busy),
      .done       (done),
      .ciphertext (ciphertext),
      .aes_op1    (aes_op1),
      .aes_op2    (aes_op2),
      .aes_sel    (aes_sel),
      .aes_result (aes_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   bit chk_en   = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // ---------------- FIPS-197 primitives (byte 0 is the leftmost byte) -------
   logic [7:0] sbox_t [256];

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] gb(input logic [127:0] v, input int i);
      return v[127-8*i -: 8];
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] v);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox_t[gb(v, i)];
      return o;
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] v);
      logic [127:0] o;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            o[127-8*(r+4*c) -: 8] = gb(v, r + 4*((c + r) % 4));
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] v);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = gb(v, 4*c); a1 = gb(v, 4*c+1); a2 = gb(v, 4*c+2); a3 = gb(v, 4*c+3);
         o[127-8*(4*c)   -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
         o[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
         o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
         o[127-8*(4*c+3) -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
      return o;
   endfunction

   function automatic logic [127:0] key_next(input logic [127:0] k, input int rnd);
      logic [31:0] w0, w1, w2, w3, t;
      logic [7:0]  rc = 8'h01;
      w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
      t  = {w3[23:0], w3[31:24]};
      t  = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
      for (int j = 1; j < rnd; j++) rc = xtime(rc);
      t  = t ^ {rc, 24'h000000};
      w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
      logic [127:0] s = pt ^ key;
      logic [127:0] k = key;
      for (int r = 1; r <= 10; r++) begin
         k = key_next(k, r);
         s = shift_rows(sub_bytes(s));
         if (r < 10) s = mix_columns(s);
         s = s ^ k;
      end
      return s;
   endfunction

   // S-box from its definition: multiplicative inverse then affine transform.
   initial begin
      logic [7:0] inv, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
         sbox_t[x] = s;
      end
   end

   // ---------------- behavioural AES operations unit -------------------------
   always_comb begin
      aes_result = '0;
      case (aes_sel)
         3'b001:  aes_result = key_next(aes_op1, int'(aes_op2[0][3:0]));
         3'b010:  aes_result = sub_bytes(aes_op1);
         3'b011:  aes_result = shift_rows(aes_op1);
         3'b100:  aes_result = mix_columns(aes_op1);
         3'b101:  aes_result = aes_op1 ^ aes_op2;
         default: aes_result = '0;
      endcase
   end

   // ---------------- expected operation trace from the round rules -----------
   int exp_sel [0:LAT];
   int exp_rnd [0:LAT];

   initial begin
      int idx;
      for (int i = 0; i <= LAT; i++) begin exp_sel[i] = 0; exp_rnd[i] = 0; end
      exp_sel[1] = 5;
      idx = 2;
      for (int r = 1; r <= 10; r++) begin
         exp_sel[idx] = 1; exp_rnd[idx] = r; idx++;
         exp_sel[idx] = 2; idx++;
         exp_sel[idx] = 3; idx++;
         if (r < 10) begin exp_sel[idx] = 4; idx++; end
         exp_sel[idx] = 5; idx++;
      end
   end

   // ---------------- transaction model --------------------------------------
   // m_phase = 0 when idle, else the 1-based cycle index inside the block.
   int           m_phase = 0;
   logic         m_done  = 1'b0;
   logic [127:0] m_ct    = '0;
   logic [127:0] m_pt    = '0;
   logic [127:0] m_key   = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_phase <= 0;
         m_done  <= 1'b0;
         m_ct    <= '0;
      end else begin
         m_done <= (m_phase == LAT);
         if (m_phase == LAT) m_ct <= aes_encrypt(m_pt, m_key);
         if (m_phase == 0) begin
            if (start) begin
               m_phase <= 1;
               m_pt    <= plaintext;
               m_key   <= cipher_key;
            end
         end else if (m_phase == LAT) begin
            m_phase <= 0;
         end else begin
            m_phase <= m_phase + 1;
         end
      end
   end

   // ---------------- per-cycle compare --------------------------------------
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", 128'(busy), 128'(m_phase != 0));
         check("done", 128'(done), 128'(m_done));
         check("ciphertext", 128'(ciphertext), m_ct);
         check("aes_sel", 128'(aes_sel), 128'(exp_sel[m_phase]));
         if (m_phase == 0)
            check("idle_op1", 128'(aes_op1), 128'h0);
         if (exp_sel[m_phase] == 1)
            check("kexp_op2", 128'(aes_op2), 128'(exp_rnd[m_phase]));
         else if (exp_sel[m_phase] != 5)
            check("op2_zero", 128'(aes_op2), 128'h0);
      end
   end

   // ---------------- directed helpers ---------------------------------------
   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Called at posedge+#1 with the DUT idle; returns at posedge+#1 of cycle 1.
   task automatic accept(input logic [127:0] pt, input logic [127:0] key, output int t_acc);
      start      = 1'b1;
      plaintext  = pt;
      cipher_key = key;
      @(posedge clk); #1;
      t_acc      = cyc;
      start      = 1'b0;
      plaintext  = rand128();
      cipher_key = rand128();
   endtask

   // Returns at the negedge of the done cycle with latency in edges.
   task automatic wait_done(input int t_acc, output int lat);
      bit found = 1'b0;
      lat = -1;
      for (int i = 0; i < 70 && !found; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            found = 1'b1;
            lat   = cyc - t_acc;
         end
      end
      if (!found) check("done_timeout", 128'(found), 128'(1'b1));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ------------------------------------------------
   initial begin
      int t1, t2, lat1, lat2;
      rst        = 1'b1;
      start      = 1'b0;
      plaintext  = '0;
      cipher_key = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_en = 1'b1;

      // Model pins against hand-known FIPS-197 values.
      check("pin_gmul", 128'(gmul(8'h57, 8'h83)), 128'h00c1);
      check("pin_sbox00", 128'(sbox_t[8'h00]), 128'h63);
      check("pin_sbox53", 128'(sbox_t[8'h53]), 128'hed);
      check("pin_model_b", aes_encrypt(PT_B, KEY_B), CT_B);

      // Reset held with start asserted: reset wins.
      start = 1'b1;
      @(negedge clk);
      check("rst_busy", 128'(busy), 128'h0);
      check("rst_done", 128'(done), 128'h0);
      check("rst_ct", 128'(ciphertext), 128'h0);
      @(posedge clk); #1;
      start = 1'b0;
      rst   = 1'b0;
      @(posedge clk); #1;

      // App. B with a start pulse and new plaintext at cycle 20.
      accept(PT_B, KEY_B, t1);
      repeat (19) @(posedge clk);
      #1;
      start     = 1'b1;
      plaintext = PT_C;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(t1, lat1);
      check("b_latency", 128'(lat1), 128'(LAT));
      check("b_ct", 128'(ciphertext), CT_B);
      @(posedge clk); #1;
      repeat (2) @(posedge clk);
      #1;

      // Reset at cycle 30 of a block, then App. C.1.
      accept(PT_B, KEY_B, t1);
      repeat (29) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy", 128'(busy), 128'h0);
      check("abort_done", 128'(done), 128'h0);
      check("abort_ct", 128'(ciphertext), 128'h0);
      @(posedge clk); #1;
      accept(PT_C, KEY_C, t1);
      wait_done(t1, lat1);
      check("c_latency", 128'(lat1), 128'(LAT));
      check("c_ct", 128'(ciphertext), CT_C);
      @(posedge clk); #1;
      repeat (3) @(posedge clk);
      #1;

      // start held high with two queued vectors: back-to-back blocks.
      start      = 1'b1;
      plaintext  = PT_B;
      cipher_key = KEY_B;
      @(posedge clk); #1;
      t1         = cyc;
      plaintext  = PT_C;
      cipher_key = KEY_C;
      wait_done(t1, lat1);
      check("b2b_ct1", 128'(ciphertext), CT_B);
      check("b2b_lat1", 128'(lat1), 128'(LAT));
      @(posedge clk); #1;
      t2         = cyc;
      start      = 1'b0;
      plaintext  = rand128();
      cipher_key = rand128();
      wait_done(t2, lat2);
      check("b2b_ct2", 128'(ciphertext), CT_C);
      check("b2b_period", 128'((t2 + lat2) - (t1 + lat1)), 128'(LAT + 1));
      @(posedge clk); #1;

      // Randomized traffic: sparse starts, random data churn, rare resets.
      repeat (500) begin
         start      = ($urandom_range(0, 3) == 0);
         plaintext  = rand128();
         cipher_key = rand128();
         rst        = ($urandom_range(0, 199) == 0);
         @(posedge clk); #1;
      end
      rst   = 1'b0;
      start = 1'b0;
      repeat (60) @(posedge clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
